// File: rtl/alu_sequencer.sv
// Register-file owner and single-command ALU sequencer (fetch A, fetch B, execute, writeback).
// Optional build macro ALU_SEQ_BLANK_ONLY_EN: commands are accepted only while display_on is low.
module alu_sequencer #(
  parameter int OPT_W = 2,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_dst,
  input  logic [2:0]       cmd_src1,
  input  logic [2:0]       cmd_src2,
  input  logic [OPT_W-1:0] cmd_optype,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic             cmd_use_carry,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic [15:0]      alu_operand1,
  output logic [15:0]      alu_operand2,
  output logic             alu_carry_in,
  output logic [OPT_W-1:0] alu_optype,
  output logic [OP_W-1:0]  alu_op,
  input  logic [15:0]      alu_result,
  input  logic             alu_carry_out,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             disp_req,
  input  logic [2:0]       disp_addr,
  output logic [15:0]      disp_data,
  input  logic             host_wr_en,
  output logic             host_wr_ready,
  input  logic [2:0]       host_wr_addr,
  input  logic [15:0]      host_wr_data,
  input  logic             display_on
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_EXEC    = 3'd3,
    S_WB      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_regs [8];
  logic [2:0]       r_dst;
  logic [2:0]       r_src1;
  logic [2:0]       r_src2;
  logic [OPT_W-1:0] r_optype;
  logic [OP_W-1:0]  r_op;
  logic             r_use_carry;
  logic [15:0]      r_opa;
  logic [15:0]      r_opb;
  logic [15:0]      r_res;
  logic             r_res_c;
  logic             r_res_z;
  logic             r_res_n;
  logic             r_flag_c;
  logic             r_flag_z;
  logic             r_flag_n;
  logic             r_done;
  logic [15:0]      r_disp_data;
  logic             w_cmd_ready;
  logic             w_accept;
  logic             w_host_ready;
  logic             w_host_wr;

`ifdef ALU_SEQ_BLANK_ONLY_EN
  assign w_cmd_ready = (r_state == S_IDLE) && !display_on;
`else
  logic w_unused_display_on;
  assign w_unused_display_on = display_on;
  assign w_cmd_ready = (r_state == S_IDLE);
`endif

  assign w_accept     = cmd_valid && w_cmd_ready;
  assign w_host_ready = (r_state != S_WB);
  assign w_host_wr    = host_wr_en && w_host_ready;

  assign cmd_ready     = w_cmd_ready;
  assign host_wr_ready = w_host_ready;
  assign done          = r_done;
  assign flag_c        = r_flag_c;
  assign flag_z        = r_flag_z;
  assign flag_n        = r_flag_n;
  assign disp_data     = r_disp_data;
  assign alu_operand1  = r_opa;
  assign alu_operand2  = r_opb;
  assign alu_optype    = r_optype;
  assign alu_op        = r_op;
  assign alu_carry_in  = r_use_carry & r_flag_c;

  // Display reads own the read port, so both fetch states stall while disp_req is high.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept)  w_next = S_FETCH_A; else w_next = S_IDLE;
      S_FETCH_A: if (!disp_req) w_next = S_FETCH_B; else w_next = S_FETCH_A;
      S_FETCH_B: if (!disp_req) w_next = S_EXEC;    else w_next = S_FETCH_B;
      S_EXEC:    w_next = S_WB;
      S_WB:      w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_EXEC);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dst       <= 3'd0;
      r_src1      <= 3'd0;
      r_src2      <= 3'd0;
      r_optype    <= '0;
      r_op        <= '0;
      r_use_carry <= 1'b0;
      r_opa       <= 16'h0000;
      r_opb       <= 16'h0000;
      r_res       <= 16'h0000;
      r_res_c     <= 1'b0;
      r_res_z     <= 1'b0;
      r_res_n     <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dst       <= cmd_dst;
        r_src1      <= cmd_src1;
        r_src2      <= cmd_src2;
        r_optype    <= cmd_optype;
        r_op        <= cmd_op;
        r_use_carry <= cmd_use_carry;
      end
      if (r_state == S_FETCH_A && !disp_req) r_opa <= r_regs[r_src1];
      if (r_state == S_FETCH_B && !disp_req) r_opb <= r_regs[r_src2];
      if (r_state == S_EXEC) begin
        r_res   <= alu_result;
        r_res_c <= alu_carry_out;
        r_res_z <= alu_zero;
        r_res_n <= alu_negative;
      end
      if (r_state == S_WB) begin
        r_flag_c <= r_res_c;
        r_flag_z <= r_res_z;
        r_flag_n <= r_res_n;
      end
    end
  end

  // Writeback outranks the host port; the host is held off by host_wr_ready during WB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
    end else if (r_state == S_WB) begin
      r_regs[r_dst] <= r_res;
    end else if (w_host_wr) begin
      r_regs[host_wr_addr] <= host_wr_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_disp_data <= 16'h0000;
    end else if (disp_req) begin
      r_disp_data <= r_regs[disp_addr];
    end
  end

endmodule
